// File: rtl/comb_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comb_bist_pkg
//  Description : Shared types, polynomials and step functions for the
//                combinational-netlist BIST driver (LFSR source, MISR sink).
//  Revision    : 1.0 - initial release
// ============================================================================
package comb_bist_pkg;

    localparam int          CNT_W     = 16;

    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1: taps at bits 63,62,60,59
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;

    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 64'd0);
    endfunction

    function automatic logic [31:0] misr_next(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'd0) ^ d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comb_bist_misr.sv
`default_nettype none
// ============================================================================
//  Module      : comb_bist_misr
//  Description : 32-bit multiple-input signature register. Reloads its seed on
//                i_load and folds i_data into the signature on i_en.
//  Revision    : 1.0 - initial release
// ============================================================================
module comb_bist_misr
    import comb_bist_pkg::*;
#(
    parameter logic [31:0] MISR_SEED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_en,
    input  logic [31:0] i_data,
    output logic [31:0] o_sig
);

    logic [31:0] r_sig;

    // Signature register: seed on reset/load, one polynomial step per enabled cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= MISR_SEED;
        end else if (i_load) begin
            r_sig <= MISR_SEED;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule
`default_nettype wire

// File: rtl/comb_bist_driver.sv
`default_nettype none
// ============================================================================
//  Module      : comb_bist_driver
//  Description : Applies PATTERN_CNT LFSR vectors to a combinational netlist,
//                compacts the responses in a MISR and compares the signature
//                with a golden value.
//                Optional macro COMB_BIST_DUAL_COMPARE_EN adds a per-cycle
//                comparison against a reference response with first-mismatch
//                index capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module comb_bist_driver
    import comb_bist_pkg::*;
#(
    parameter int          IN_W        = 41,
    parameter int          OUT_W       = 21,
    parameter int          PATTERN_CNT = 1024,
    parameter int          RESP_LAT    = 0,
    parameter logic [63:0] LFSR_SEED   = 64'hACE1_0000_0000_0001,
    parameter logic [31:0] MISR_SEED   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [IN_W-1:0]  pat_o,
    input  logic [OUT_W-1:0] resp_i,
    input  logic [31:0]      golden_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [31:0]      sig_o,
    output logic             pass_o
`ifdef COMB_BIST_DUAL_COMPARE_EN
    ,
    input  logic [OUT_W-1:0] ref_resp_i,
    output logic             mism_o,
    output logic [CNT_W-1:0] mism_idx_o
`endif
);

    state_t            r_state;
    logic [63:0]       r_lfsr;
    logic [IN_W-1:0]   r_pat;
    logic [CNT_W-1:0]  r_pat_cnt;
    logic [1:0]        r_drain_cnt;
    logic [31:0]       r_golden;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;

    logic [63:0]       w_lfsr_nxt;
    logic              w_run;
    logic              w_last;
    logic              w_cap;
    logic              w_cap_en;
    logic              w_load;
    logic [31:0]       w_sig;
    logic              w_cmp_ok;

    assign w_lfsr_nxt = lfsr_next(r_lfsr);
    assign w_run      = (r_state == RUN);
    assign w_last     = (r_pat_cnt == CNT_W'(PATTERN_CNT - 1));
    // Abort wins over everything, including a pending MISR update or seed load
    assign w_cap_en   = w_cap && !abort_i;
    assign w_load     = (r_state == SEED) && !abort_i;

    // Response-valid pipe: a RUN cycle becomes a capture cycle RESP_LAT cycles later
    generate
        if (RESP_LAT == 0) begin : g_lat_zero
            assign w_cap = w_run;
        end else begin : g_lat_pipe
            logic [RESP_LAT-1:0] r_vpipe;

            // Shift RUN-cycle markers toward the capture tap; flushed on seed/abort
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vpipe <= '0;
                end else if (abort_i || r_state == SEED) begin
                    r_vpipe <= '0;
                end else begin
                    r_vpipe <= (r_vpipe << 1) | RESP_LAT'(w_run);
                end
            end

            assign w_cap = r_vpipe[RESP_LAT-1];
        end
    endgenerate

    // Sequencer: owns the FSM, LFSR, pattern counter and all registered flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lfsr      <= '0;
            r_pat       <= '0;
            r_pat_cnt   <= '0;
            r_drain_cnt <= '0;
            r_golden    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (abort_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state  <= SEED;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_golden <= golden_i;
                    end
                end
                SEED: begin
                    r_lfsr    <= LFSR_SEED;
                    r_pat     <= LFSR_SEED[IN_W-1:0];
                    r_pat_cnt <= '0;
                    r_state   <= RUN;
                end
                RUN: begin
                    r_lfsr <= w_lfsr_nxt;
                    if (w_last) begin
                        // Last vector stays on the pads through DRAIN
                        r_drain_cnt <= '0;
                        r_state     <= (RESP_LAT == 0) ? DONE : DRAIN;
                    end else begin
                        r_pat_cnt <= r_pat_cnt + 16'd1;
                        r_pat     <= w_lfsr_nxt[IN_W-1:0];
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == 2'(RESP_LAT - 1)) begin
                        r_state <= DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_sig == r_golden) && w_cmp_ok;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    comb_bist_misr #(
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_en   (w_cap_en),
        .i_data (32'(resp_i)),
        .o_sig  (w_sig)
    );

`ifdef COMB_BIST_DUAL_COMPARE_EN
    logic [CNT_W-1:0] r_resp_cnt;
    logic             r_mism;
    logic [CNT_W-1:0] r_mism_idx;

    // Response counter gives the vector index of each capture; first mismatch is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_cnt <= '0;
            r_mism     <= 1'b0;
            r_mism_idx <= '0;
        end else if (w_load) begin
            r_resp_cnt <= '0;
            r_mism     <= 1'b0;
            r_mism_idx <= '0;
        end else if (w_cap_en) begin
            r_resp_cnt <= r_resp_cnt + 16'd1;
            if (!r_mism && (resp_i != ref_resp_i)) begin
                r_mism     <= 1'b1;
                r_mism_idx <= r_resp_cnt;
            end
        end
    end

    assign w_cmp_ok   = !r_mism;
    assign mism_o     = r_mism;
    assign mism_idx_o = r_mism_idx;
`else
    assign w_cmp_ok   = 1'b1;
`endif

    assign pat_o  = r_pat;
    assign busy_o = r_busy;
    assign done_o = r_done;
    assign sig_o  = w_sig;
    assign pass_o = r_pass;

endmodule
`default_nettype wire
